mmio_uart_tx: RTL

- Memory-mapped serial transmit peripheral; the bus responder for CPU load/store accesses.
- Presents the same synchronous-RAM-style target interface as main RAM: word address, 4-bit byte enables, write data, write enable, registered read data.
- Accepts bytes from the CPU into a TX FIFO and serialises them on txd as 8N1 frames, LSB first.
- Sits beside RAM on the CPU data port, selected by an address decode outside the block (cs).

---
 rtl/mmio_uart_tx.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter.
// Sits on the CPU data port beside RAM and uses the same synchronous-RAM-style
// target interface: word address, byte enables, write data, write strobe and
// one-cycle registered read data.
//
// Bus semantics: there is no valid/ready handshake. An access happens in
// every cycle where cs=1. When wren=1 as well, the write takes effect at that
// clock edge. A read of the addressed register is captured into q at the same
// edge and returns the value from before the edge. When cs=0, q is cleared.
//
// Register map (word index):
//   0 DATA     write byte lane 0 to push a byte; reads return 0
//   1 STATUS   {count[12:4], overflow[3], busy[2], empty[1], full[0]}
//              writing bit3=1 on lane 0 clears overflow
//   2 DIVISOR  clocks per bit [15:0]; lanes 0 and 1 are written independently
//   3 CTRL     bit0 tx_enable
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic [1:0]  address,
    input  logic [3:0]  byteena,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic        txd,
    output logic        irq
);

    localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0] DEPTH_CNT = 9'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [8:0]       count;
    logic [8:0]       count_next;
    logic [7:0]       head;

    // Software-visible control and status
    logic             overflow;
    logic [15:0]      divisor;
    logic             tx_enable;

    // Transmitter
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [15:0]      bit_cnt;
    logic [15:0]      div_latched;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Decoded bus strobes
    logic             wr_hit;
    logic             push_req;
    logic             ovf_clr;
    logic             div_wr_lo;
    logic             div_wr_hi;
    logic             ctrl_wr;

    // Derived conditions
    logic             fifo_full;
    logic             fifo_empty;
    logic             busy;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    logic             bit_done;
    logic [15:0]      eff_div;
    logic [31:0]      read_mux;

    assign wr_hit    = cs && wren;
    assign push_req  = wr_hit && (address == ADDR_DATA)   && byteena[0];
    assign ovf_clr   = wr_hit && (address == ADDR_STATUS) && byteena[0] && data[3];
    assign div_wr_lo = wr_hit && (address == ADDR_DIV)    && byteena[0];
    assign div_wr_hi = wr_hit && (address == ADDR_DIV)    && byteena[1];
    assign ctrl_wr   = wr_hit && (address == ADDR_CTRL)   && byteena[0];

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == 9'd0);
    assign busy       = (state != ST_IDLE);

    // A frame start consumes the head entry, which frees a slot for a push
    // landing in the same cycle even when the FIFO is full.
    assign pop       = (state == ST_IDLE) && tx_enable && !fifo_empty;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    // Divisors 0 and 1 both mean one clock per bit.
    assign eff_div  = (divisor < 16'd2) ? 16'd1 : divisor;
    assign bit_done = (bit_cnt == 16'd0);
    assign head     = fifo_mem[rd_ptr];

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 9'd1;
            2'b01:   count_next = count - 9'd1;
            default: count_next = count;
        endcase
    end

    // Next transmitter state: IDLE -> START -> DATA (8 bits) -> STOP -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pop)                              state_next = ST_START;
            ST_START: if (bit_done)                         state_next = ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx == 3'd7))    state_next = ST_STOP;
            ST_STOP:  if (bit_done)                         state_next = ST_IDLE;
            default:                                        state_next = ST_IDLE;
        endcase
    end

    // Read mux over the register map, using pre-edge register values
    always_comb begin
        read_mux = 32'd0;
        case (address)
            ADDR_DATA:   read_mux = 32'd0;
            ADDR_STATUS: read_mux = {19'd0, count, overflow, busy, fifo_empty, fifo_full};
            ADDR_DIV:    read_mux = {16'd0, divisor};
            ADDR_CTRL:   read_mux = {31'd0, tx_enable};
            default:     read_mux = 32'd0;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 9'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Control registers: sticky overflow (set beats clear), divisor lanes, enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            divisor   <= DEFAULT_DIV;
            tx_enable <= 1'b1;
        end else begin
            if (push_drop)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (div_wr_lo) divisor[7:0]  <= data[7:0];
            if (div_wr_hi) divisor[15:8] <= data[15:8];
            if (ctrl_wr)   tx_enable     <= data[0];
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit timing and serial data; txd is registered so it changes with state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= 16'd0;
            div_latched <= 16'd1;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'd0;
            txd         <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        // Divisor is sampled once per frame so mid-frame
                        // writes only affect the next frame.
                        shift_reg   <= head;
                        div_latched <= eff_div;
                        bit_cnt     <= eff_div - 16'd1;
                        txd         <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_cnt <= div_latched - 16'd1;
                        bit_idx <= 3'd0;
                        txd     <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= div_latched - 16'd1;
                        if (bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    txd <= 1'b1;
                    if (!bit_done) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    txd <= 1'b1;
                end
            endcase
        end
    end

    // Interrupt: FIFO empty and transmitter idle, computed from next-state values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b1;
        end else begin
            irq <= (count_next == 9'd0) && (state_next == ST_IDLE);
        end
    end

    // Registered read data; zero when the block is not selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 32'd0;
        end else begin
            q <= cs ? read_mux : 32'd0;
        end
    end

endmodule
